// File: rtl/div_pkg.sv
// Shared types and defaults for the restoring divider: FSM state codes and default width.
package div_pkg;

    localparam int DIV_W_DEFAULT = 8;

    // The state code is exported on `ready`, so the encoding is fixed rather than left to the tool.
    typedef enum logic [2:0] {
        IDLE = 3'b000,
        LOAD = 3'b001,
        CALC = 3'b010,
        DONE = 3'b100
    } div_state_t;

endpackage

// File: rtl/divider_fsm_if.sv
// Request/result bundle for divider_fsm: the requester drives the master side, the divider the slave side.
interface divider_fsm_if
    import div_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
);
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [2:0]   ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, quotient, remainder, div_zero
    );
endinterface

// File: rtl/div_datapath.sv
// Restoring-division datapath: working remainder/quotient shift registers and the trial subtractor.
// With DIV_SIGNED_EN defined, operands are taken as magnitudes and the result signs are fixed on the way out.
module div_datapath
    import div_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] res_quot,
    output logic [W-1:0] res_rem
);
    logic [W-1:0] q_q, q_d;
    logic [W-1:0] rem_q, rem_d;
    logic [W-1:0] dvs_q, dvs_d;
    logic [W:0]   trial;
    logic [W-1:0] a_mag, b_mag;

`ifdef DIV_SIGNED_EN
    logic neg_a_q, neg_a_d;
    logic neg_b_q, neg_b_d;

    // The most-negative value maps onto itself, which reads correctly as an unsigned magnitude.
    assign a_mag = dividend[W-1] ? -dividend : dividend;
    assign b_mag = divisor[W-1]  ? -divisor  : divisor;
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
`endif

    // NOTE: every variable written here gets a value before any branch, so no latch can be inferred.
    always_comb begin
        q_d   = q_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        trial = {rem_q, q_q[W-1]} - {1'b0, dvs_q};
`ifdef DIV_SIGNED_EN
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
`endif
        if (load) begin
            q_d   = a_mag;
            rem_d = '0;
            dvs_d = b_mag;
`ifdef DIV_SIGNED_EN
            neg_a_d = dividend[W-1];
            neg_b_d = divisor[W-1];
`endif
        end else if (step) begin
            if (!trial[W]) begin
                rem_d = trial[W-1:0];
                q_d   = {q_q[W-2:0], 1'b1};
            end else begin
                rem_d = {rem_q[W-2:0], q_q[W-1]};
                q_d   = {q_q[W-2:0], 1'b0};
            end
        end
    end

    // Results come from the next-state values so the final step lands in the output registers.
`ifdef DIV_SIGNED_EN
    assign res_quot = (neg_a_q ^ neg_b_q) ? -q_d : q_d;
    assign res_rem  = neg_a_q ? -rem_d : rem_d;
`else
    assign res_quot = q_d;
    assign res_rem  = rem_d;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= '0;
            rem_q <= '0;
            dvs_q <= '0;
`ifdef DIV_SIGNED_EN
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
`endif
        end else begin
            q_q   <= q_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
`ifdef DIV_SIGNED_EN
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
`endif
        end
    end

endmodule

// File: rtl/divider_fsm.sv
// Sequential restoring divider, one quotient bit per clock; exposes its state code on `ready`.
// Optional two's-complement mode via DIV_SIGNED_EN (implemented inside div_datapath).
module divider_fsm
    import div_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    divider_fsm_if.slave   bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    div_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0] quot_q, quot_d;
    logic [W-1:0] rem_q, rem_d;
    logic         dz_q, dz_d;
    logic         load, step;
    logic [W-1:0] res_quot, res_rem;

    div_datapath #(.W(W)) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .dividend (bus.dividend),
        .divisor  (bus.divisor),
        .res_quot (res_quot),
        .res_rem  (res_rem)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: if (bus.start) state_d = LOAD;
            LOAD: begin
                load  = 1'b1;
                cnt_d = CW'(W - 1);
                if (bus.divisor == '0) begin
                    quot_d  = '1;
                    rem_d   = bus.dividend;
                    dz_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    dz_d    = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt_q == '0) begin
                    quot_d  = res_quot;
                    rem_d   = res_rem;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.ready     = state_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_divider_fsm.sv
// Self-checking bench for divider_fsm: directed vectors, an arithmetic reference model and a result scoreboard.
module tb_divider_fsm;
    localparam int W = 8;

`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    divider_fsm_if #(.W(W)) bus ();

    divider_fsm #(.W(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division with the divide-by-zero and overflow rules layered on top.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dz = 1'b1;
        end else begin
            e.dz = 1'b0;
`ifdef DIV_SIGNED_EN
            begin
                int sa, sb;
                sa = int'($signed(a));
                sb = int'($signed(b));
                if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
                    e.q = a; e.r = '0;
                end else begin
                    e.q = W'(sa / sb);
                    e.r = W'(sa % sb);
                end
            end
`else
            e.q = a / b;
            e.r = a % b;
`endif
        end
        return e;
    endfunction

    // Compare process: every DONE must match the oldest outstanding request; ready must be a legal code.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("ready_legal", {31'd0, bus.ready inside {3'b000, 3'b001, 3'b010, 3'b100}}, 32'd1);
                if (bus.ready == 3'b100) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("model_quotient",  {24'd0, bus.quotient},  {24'd0, e.q});
                        check("model_remainder", {24'd0, bus.remainder}, {24'd0, e.r});
                        check("model_div_zero",  {31'd0, bus.div_zero},  {31'd0, e.dz});
                    end
                end
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit lit_en, input logic [W-1:0] lq, input logic [W-1:0] lr,
                          input logic ldz, input bit hold, input bit chg);
        int edges;
        bit seen;
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        exp_q.push_back(model(a, b));
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 40) begin
            @(negedge clk);
            edges++;
            if (!hold) bus.start = 1'b0;
            if (chg && bus.ready == 3'b010) begin
                bus.dividend = W'($urandom);
                bus.divisor  = W'($urandom);
            end
            if (bus.ready == 3'b100) seen = 1'b1;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        check("latency", edges, (b == '0) ? 32'd2 : 32'(W + 2));
        if (lit_en && seen) begin
            check("lit_quotient",  {24'd0, bus.quotient},  {24'd0, lq});
            check("lit_remainder", {24'd0, bus.remainder}, {24'd0, lr});
            check("lit_div_zero",  {31'd0, bus.div_zero},  {31'd0, ldz});
        end
        @(negedge clk);
        check("idle_after_done", {29'd0, bus.ready}, 32'd0);
        bus.start = 1'b0;
    endtask

    initial begin
        exp_t m;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready",     {29'd0, bus.ready},     32'd0);
        check("reset_quotient",  {24'd0, bus.quotient},  32'd0);
        check("reset_remainder", {24'd0, bus.remainder}, 32'd0);
        check("reset_div_zero",  {31'd0, bus.div_zero},  32'd0);
        rst = 1'b0;

`ifndef DIV_SIGNED_EN
        m = model(8'd200, 8'd23);
        check("pin_model_q", {24'd0, m.q}, 32'd8);
        check("pin_model_r", {24'd0, m.r}, 32'd16);
        m = model(8'd19, 8'd23);
        check("pin_model_q_small", {24'd0, m.q}, 32'd0);
`else
        m = model(8'hF9, 8'h02);
        check("pin_model_q", {24'd0, m.q}, 32'hFD);
        check("pin_model_r", {24'd0, m.r}, 32'hFF);
        m = model(8'h80, 8'hFF);
        check("pin_model_q_ovf", {24'd0, m.q}, 32'h80);
`endif

        // Unsigned directed vectors; literal expectations apply only to the unsigned build.
        run_op(8'd200, 8'd23, !SIGNED_BUILD, 8'd8,   8'd16, 1'b0, 1'b0, 1'b0);
        run_op(8'd255, 8'd1,  !SIGNED_BUILD, 8'd255, 8'd0,  1'b0, 1'b0, 1'b0);
        run_op(8'd19,  8'd23, !SIGNED_BUILD, 8'd0,   8'd19, 1'b0, 1'b0, 1'b0);
        run_op(8'd0,   8'd5,  !SIGNED_BUILD, 8'd0,   8'd0,  1'b0, 1'b0, 1'b0);
        run_op(8'h17,  8'd0,  1'b1,          8'hFF,  8'h17, 1'b1, 1'b0, 1'b0);
        run_op(8'd50,  8'd7,  !SIGNED_BUILD, 8'd7,   8'd1,  1'b0, 1'b0, 1'b0);

        // Start held for the whole op and operands scrambled during CALC.
        run_op(8'd250, 8'd9,  !SIGNED_BUILD, 8'd27,  8'd7,  1'b0, 1'b1, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("stays_idle", {29'd0, bus.ready}, 32'd0);
        end

        // Reset during the third CALC cycle aborts the operation.
        @(negedge clk);
        bus.dividend = 8'd200;
        bus.divisor  = 8'd23;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("calc_before_rst", {29'd0, bus.ready}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready",     {29'd0, bus.ready},     32'd0);
        check("rst_quotient",  {24'd0, bus.quotient},  32'd0);
        check("rst_remainder", {24'd0, bus.remainder}, 32'd0);
        check("rst_div_zero",  {31'd0, bus.div_zero},  32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("no_done_after_rst", {29'd0, bus.ready}, 32'd0);
        run_op(8'd100, 8'd7, !SIGNED_BUILD, 8'd14, 8'd2, 1'b0, 1'b0, 1'b0);

`ifdef DIV_SIGNED_EN
        run_op(8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_op(8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0);
`endif

        // A few pseudo-random operands checked against the model only.
        for (int i = 0; i < 6; i++) begin
            run_op(W'($urandom), W'($urandom_range(0, 255)), 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
